// File: rtl/id_hazard_ctrl_if.sv
// ID-stage hazard control bus: decoded instruction fields, pipeline controls,
// writeback bus, and the scheduler's decisions. The master drives the
// instruction and writeback fields. The slave, which is the scheduler, drives
// the stall, issue, pending and error outputs.
interface id_hazard_ctrl_if #(
   parameter int unsigned NREG = 16
);
   localparam int unsigned AW = $clog2(NREG);

   logic          id_valid_i;
   logic [AW-1:0] id_rd_i;
   logic [AW-1:0] id_rs_i;
   logic          id_use_rd_i;
   logic          id_use_rs_i;
   logic          id_wr_i;
   logic          stall_i;
   logic          flush_i;
   logic          wb_i;
   logic [AW-1:0] wb_r_i;

   logic            stall_o;
   logic            issue_o;
   logic [NREG-1:0] pending_o;
   logic            err_o;

   modport master (
      output id_valid_i, id_rd_i, id_rs_i, id_use_rd_i, id_use_rs_i, id_wr_i,
      output stall_i, flush_i, wb_i, wb_r_i,
      input  stall_o, issue_o, pending_o, err_o
   );

   modport slave (
      input  id_valid_i, id_rd_i, id_rs_i, id_use_rd_i, id_use_rs_i, id_wr_i,
      input  stall_i, flush_i, wb_i, wb_r_i,
      output stall_o, issue_o, pending_o, err_o
   );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Register-interlock scheduler for the ID stage. Each architectural register
// has a saturating counter of writes that are in flight to it. The scheduler
// holds ID while a source register is busy, or while one more write to the
// destination register would overflow its counter.
// Optional build macro ID_HAZARD_WB_BYPASS_EN: a final writeback that arrives
// in the same cycle clears the source hazard, because the register file
// writes through.
module id_hazard_ctrl #(
   parameter int unsigned NREG  = 16,
   parameter int unsigned CNT_W = 2
) (
   input logic                clk,
   input logic                rst,
   id_hazard_ctrl_if.slave    bus
);
   localparam int unsigned AW = $clog2(NREG);
   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q [NREG];
   logic [CNT_W-1:0] cnt_d [NREG];
   logic             err_q;
   logic             err_d;

   logic [CNT_W-1:0] rs_cnt;
   logic [CNT_W-1:0] rd_cnt;
   logic             rs_busy;
   logic             rd_busy;
   logic             src_hz;
   logic             sat_hz;
   logic             stall;
   logic             issue;

   // Hazard detection and the issue decision, with zero latency from the inputs.
   always_comb begin
      rs_cnt = cnt_q[bus.id_rs_i];
      rd_cnt = cnt_q[bus.id_rd_i];
`ifdef ID_HAZARD_WB_BYPASS_EN
      rs_busy = (rs_cnt > CntOne) |
                ((rs_cnt == CntOne) & ~(bus.wb_i & (bus.wb_r_i == bus.id_rs_i)));
      rd_busy = (rd_cnt > CntOne) |
                ((rd_cnt == CntOne) & ~(bus.wb_i & (bus.wb_r_i == bus.id_rd_i)));
`else
      rs_busy = (rs_cnt != '0);
      rd_busy = (rd_cnt != '0);
`endif
      // Hazards come only from scoreboard state. An instruction whose rd equals
      // its rs never stalls on its own write.
      src_hz = (bus.id_use_rs_i & rs_busy) | (bus.id_use_rd_i & rd_busy);
      sat_hz = bus.id_wr_i & (rd_cnt == CntMax);
      stall  = rst | bus.stall_i | (bus.id_valid_i & (src_hz | sat_hz));
      issue  = bus.id_valid_i & ~stall & ~bus.flush_i;
   end

   // Next-state computation for the counters and the sticky underflow flag.
   always_comb begin
      for (int unsigned n = 0; n < NREG; n++) begin
         logic inc;
         logic dec;
         inc = issue & bus.id_wr_i & (bus.id_rd_i == AW'(n));
         dec = bus.wb_i & (bus.wb_r_i == AW'(n)) & (cnt_q[n] != '0);
         cnt_d[n] = cnt_q[n];
         if (inc && !dec) begin
            cnt_d[n] = cnt_q[n] + CntOne;
         end else if (dec && !inc) begin
            cnt_d[n] = cnt_q[n] - CntOne;
         end
      end
      // A writeback to a register with no pending write is a bookkeeping error.
      err_d = err_q | (bus.wb_i & (cnt_q[bus.wb_r_i] == '0));
   end

   // State registers, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned n = 0; n < NREG; n++) begin
            cnt_q[n] <= '0;
         end
         err_q <= 1'b0;
      end else begin
         for (int unsigned n = 0; n < NREG; n++) begin
            cnt_q[n] <= cnt_d[n];
         end
         err_q <= err_d;
      end
   end

   // Outputs. The reset gating hides any stale state during the first reset cycle.
   always_comb begin
      for (int unsigned n = 0; n < NREG; n++) begin
         bus.pending_o[n] = ~rst & (cnt_q[n] != '0);
      end
      bus.stall_o = stall;
      bus.issue_o = issue;
      bus.err_o   = ~rst & err_q;
   end
endmodule
